// File: rtl/instr_mem_resp.sv
// ---------------------------------------------------------------------------
// instr_mem_resp
//
// Purpose:
//   Responder end of the instruction-fetch interface. A fetch address is
//   accepted on the request channel and the word is read from a local
//   word-addressed instruction memory. The word is returned on the response
//   channel a fixed LATENCY cycles after acceptance. Only one request is in
//   flight at a time. A separate load port writes program contents at any
//   time.
//
// Handshake rule (both channels):
//   A transfer happens on a rising clk edge where valid && ready are both
//   high. The requester holds req_valid/req_addr stable until it is accepted.
//   resp_data/resp_err stay stable while resp_valid && !resp_ready.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   req_valid   in   fetch request present
//   req_addr    in   fetch word address [ADDR_W]
//   req_ready   out  responder can accept a request this cycle
//   resp_valid  out  response word available
//   resp_data   out  fetched instruction [DATA_W] (0 when out of range)
//   resp_err    out  fetched address was >= DEPTH
//   resp_ready  in   consumer accepts the response this cycle
//   load_en     in   write load_data into memory at load_addr
//   load_addr   in   load word address [ADDR_W]
//   load_data   in   load word [DATA_W]
//   dbg_state   out  current FSM state (0 idle, 1 busy, 2 resp)
// ---------------------------------------------------------------------------
module instr_mem_resp #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              resp_ready,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Index width of the memory array; DEPTH <= 2**ADDR_W keeps it <= ADDR_W.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened by one bit so DEPTH == 2**ADDR_W is still representable
    // in the unsigned range compare.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    // The acceptance edge counts as the first latency cycle, so the counter
    // starts at LATENCY-1 and the response appears at edge T+LATENCY.
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    // -----------------------------------------------------------------------
    // Instruction memory (not reset; contents survive reset)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              load_in_range;
    logic              req_in_range;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W-1:0]  req_idx;

    // Out-of-range addresses are rejected outright rather than aliased by
    // dropping upper address bits.
    assign load_in_range = ({1'b0, load_addr} < DEPTH_X);
    assign req_in_range  = ({1'b0, req_addr}  < DEPTH_X);
    assign load_idx      = load_addr[IDX_W-1:0];
    assign req_idx       = req_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem_q[load_idx] <= load_data;
        end
    end

    // -----------------------------------------------------------------------
    // FSM state and response hold registers
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [2:0]        cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              err_q,   err_d;
    logic              req_fire;

    // Process 1: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_fire = req_valid && req_ready;

    // Process 2: next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_INIT;
                    // The word is captured on the acceptance edge from the
                    // memory's current contents, so a load landing on the
                    // same edge or later cannot change this response.
                    data_d  = req_in_range ? mem_q[req_idx] : '0;
                    err_d   = !req_in_range;
                end
            end
            S_BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    data_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Process 3: outputs
    always_comb begin
        // req_ready is held low while reset is asserted so nothing can be
        // counted as accepted during reset.
        req_ready  = (state_q == S_IDLE) && !reset;
        resp_valid = (state_q == S_RESP);
        // The hold register is already loaded during BUSY; mask it so the
        // data/err outputs read zero whenever no response is offered.
        resp_data  = (state_q == S_RESP) ? data_q : '0;
        resp_err   = (state_q == S_RESP) ? err_q  : 1'b0;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_instr_mem_resp.sv
module tb_instr_mem_resp;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int D0 = 200;
  localparam int L0 = 2;
  localparam int D1 = 256;
  localparam int L1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: DEPTH=200, LATENCY=2 ----------------
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          resp_ready = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic [1:0]    dbg_state;

  instr_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D0), .LATENCY(L0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .resp_ready(resp_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT 1: DEPTH=256, LATENCY=1 ----------------
  logic          req_valid1 = 1'b0;
  logic [AW-1:0] req_addr1 = '0;
  logic          req_ready1;
  logic          resp_valid1;
  logic [DW-1:0] resp_data1;
  logic          resp_err1;
  logic          resp_ready1 = 1'b1;
  logic          load_en1 = 1'b0;
  logic [AW-1:0] load_addr1 = '0;
  logic [DW-1:0] load_data1 = '0;
  logic [1:0]    dbg_state1;

  instr_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D1), .LATENCY(L1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
    .resp_valid(resp_valid1), .resp_data(resp_data1), .resp_err(resp_err1),
    .resp_ready(resp_ready1),
    .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1),
    .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad = 0;
  logic [DW-1:0] ref_mem [256];
  bit rnd_loads = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: the reference memory takes any load present at the edge;
  // inputs are then changed 1ns after the edge.
  task automatic tick();
    logic          le;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    le = load_en;
    la = load_addr;
    ld = load_data;
    @(posedge clk);
    if (le && (int'(la) < D0)) ref_mem[la] = ld;
    #1;
    load_en = 1'b0;
    if (rnd_loads && ($urandom_range(0, 2) == 0)) begin
      load_en = 1'b1;
      load_addr = AW'($urandom_range(0, 255));
      load_data = $urandom;
    end
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
  endtask

  // Full fetch on DUT 0 with an optional response stall of 'stall' cycles.
  task automatic fetch(input logic [AW-1:0] addr, input int stall);
    logic [DW-1:0] ed;
    logic          ee;
    int            guard;
    req_valid = 1'b1;
    req_addr = addr;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("req_ready_idle", req_ready, 1);
    ee = (int'(addr) >= D0);
    ed = ee ? '0 : ref_mem[addr];
    tick();                       // acceptance edge T
    req_valid = 1'b0;
    chk("busy_req_ready", req_ready, 0);
    chk("busy_no_valid", resp_valid, 0);
    for (int i = 1; i < L0; i++) begin
      tick();
      chk("busy_no_valid", resp_valid, 0);
      chk("busy_req_ready", req_ready, 0);
    end
    tick();                       // edge T+LATENCY
    chk("resp_valid", resp_valid, 1);
    chk("resp_data", resp_data, ed);
    chk("resp_err", resp_err, ee);
    if (stall > 0) begin
      resp_ready = 1'b0;
      req_valid = 1'b1;           // must be ignored while busy
      req_addr = AW'($urandom_range(0, 255));
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("stall_valid", resp_valid, 1);
        chk("stall_data", resp_data, ed);
        chk("stall_err", resp_err, ee);
        chk("stall_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      req_valid = 1'b0;
    end
    tick();
    chk("post_valid", resp_valid, 0);
    chk("post_data", resp_data, 0);
    chk("post_err", resp_err, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("no_spurious_valid", resp_valid, 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [AW-1:0] a6 [3];
    int resp_cyc[$];
    int acc_cyc[$];
    int idx;
    bit acc;

    #1 reset = 1'b1;
    #11;
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_valid1", resp_valid1, 0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_req_ready1", req_ready1, 1);

    // Fill memory; loads to >= DEPTH are dropped by DUT and model alike.
    for (int a = 0; a < 256; a++) do_load(AW'(a), $urandom);
    do_load(8'h00, 32'h11111111);
    do_load(8'h05, 32'hDEADBEEF);

    // 1: basic fetch, latency 2
    fetch(8'h05, 0);
    // 2: four-cycle stall, bait request ignored
    fetch(8'h00, 4);
    quiet(L0 + 2);
    // 3: out-of-range, boundary and dropped load
    fetch(8'hC8, 0);
    do_load(8'hC8, 32'h12345678);
    fetch(8'hC8, 0);
    fetch(8'hC7, 1);
    fetch(8'hFF, 0);
    // 4: same-cycle load returns old data, next fetch sees new data
    load_en = 1'b1;
    load_addr = 8'h05;
    load_data = 32'hCAFEF00D;
    fetch(8'h05, 0);
    fetch(8'h05, 0);

    // 5a: reset during BUSY
    req_valid = 1'b1;
    req_addr = 8'h05;
    tick();
    req_valid = 1'b0;
    chk("r5_busy_valid", resp_valid, 0);
    #2 reset = 1'b1;
    #1;
    chk("r5_busy_rst_valid", resp_valid, 0);
    #1 reset = 1'b0;
    #1;
    chk("r5_busy_idle", req_ready, 1);
    quiet(L0 + 1);
    // 5b: reset during RESP
    req_valid = 1'b1;
    req_addr = 8'h05;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < L0; i++) tick();
    chk("r5_resp_valid", resp_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("r5_resp_rst_valid", resp_valid, 0);
    chk("r5_resp_rst_data", resp_data, 0);
    chk("r5_resp_rst_err", resp_err, 0);
    #1 reset = 1'b0;
    #1;
    chk("r5_resp_idle", req_ready, 1);
    quiet(L0 + 1);
    fetch(8'h05, 0);

    // Random traffic with loads landing at arbitrary times
    rnd_loads = 1;
    for (int n = 0; n < 40; n++) fetch(AW'($urandom_range(0, 255)), $urandom_range(0, 3));
    rnd_loads = 0;
    tick();

    // 6: back-to-back on the LATENCY=1 instance
    load_en1 = 1'b1; load_addr1 = 8'h00; load_data1 = 32'h11111111;
    tick();
    load_addr1 = 8'h05; load_data1 = 32'hDEADBEEF;
    tick();
    load_en1 = 1'b0;
    a6[0] = 8'h00; a6[1] = 8'h05; a6[2] = 8'h00;
    exp_q = {32'h11111111, 32'hDEADBEEF, 32'h11111111};
    idx = 0;
    resp_ready1 = 1'b1;
    req_addr1 = a6[0];
    req_valid1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = req_valid1 && req_ready1;
      tick();
      if (acc) begin
        acc_cyc.push_back(c);
        idx++;
        if (idx < 3) req_addr1 = a6[idx];
        else req_valid1 = 1'b0;
      end
      if (resp_valid1) begin
        resp_cyc.push_back(c);
        if (exp_q.size() > 0) chk("b2b_data", resp_data1, exp_q.pop_front());
        else chk("b2b_extra_valid", resp_valid1, 0);
        chk("b2b_err", resp_err1, 0);
      end
    end
    chk("b2b_count", resp_cyc.size(), 3);
    chk("b2b_acc_count", acc_cyc.size(), 3);
    if (resp_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("b2b_latency", resp_cyc[0] - acc_cyc[0], L1);
    for (int i = 1; i < resp_cyc.size(); i++)
      chk("b2b_spacing", resp_cyc[i] - resp_cyc[i-1], L1 + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_resp.md
Name: instr_mem_resp

Overview:
- Responder end of the instruction-fetch interface.
- Accepts fetch addresses issued by the program-counter/fetch logic over a valid/ready request channel.
- Reads a word-addressed instruction memory and returns the instruction on a valid/ready response channel after a fixed, parameterised latency.
- Provides a load port through which the bench or boot logic writes program contents.

Parameters:
ADDR_W, 8, fetch/load address width in bits
DATA_W, 32, instruction word width in bits
DEPTH, 256, number of implemented words (must be <= 2**ADDR_W)
LATENCY, 2, cycles from request acceptance to resp_valid (legal range 1..7)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  fetch request present
req_addr  input  ADDR_W  fetch word address
req_ready  output  1  responder can accept a request this cycle
resp_valid  output  1  response word available
resp_data  output  DATA_W  fetched instruction
resp_err  output  1  fetched address was >= DEPTH
resp_ready  input  1  consumer accepts response this cycle
load_en  input  1  write load_data into memory at load_addr
load_addr  input  ADDR_W  load word address
load_data  input  DATA_W  load word

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, req_ready=1 once reset deasserts, resp_valid=0, resp_data=0, resp_err=0, latency counter=0. Memory array is not cleared.
- State IDLE:
  - req_ready=1.
  - On req_valid&&req_ready (acceptance cycle T): memory is read at req_addr and the word is captured into an internal hold register in that same edge; err=(req_addr>=DEPTH), and the word is 0 when err; counter=LATENCY-1; go BUSY.
- State BUSY:
  - req_ready=0; counter decrements each cycle.
  - When counter==0, next state is RESP; resp_valid rises at edge T+LATENCY.
- State RESP:
  - resp_valid=1; resp_data/resp_err hold stable while resp_valid&&!resp_ready.
  - req_ready=0.
  - On resp_ready: resp_valid=0, resp_data=0, resp_err=0 next cycle; go IDLE.
- Throughput: one request every LATENCY+2 cycles minimum with resp_ready held high. No pipelining; one outstanding request.
- Requests with req_valid high while req_ready=0 are ignored; the requester must hold req_valid/req_addr until accepted.
- Load port:
  - Writes on any cycle in any state; a write with load_addr>=DEPTH is dropped.
  - Read-vs-write priority: the read data is sampled at acceptance. A load to the same address in cycle T does not affect that fetch (old data returned). A load in T+1..T+LATENCY also does not affect the in-flight response.
  - A fetch accepted in a cycle after the load edge sees the new data.
- Reset mid-operation (BUSY or RESP): the in-flight response is discarded and resp_valid drops immediately (asynchronously). Memory contents persist.
- resp_valid never asserts without a prior accepted request; exactly one response per accepted request.
- Address arithmetic is unsigned; no wrap — out-of-range addresses return error, not an aliased word.

Test Plan:
1. Load mem[0x00]=0x11111111 and mem[0x05]=0xDEADBEEF. Request 0x05 at cycle T with resp_ready=1, LATENCY=2 -> resp_valid=1 with resp_data=0xDEADBEEF, resp_err=0 at T+2 for one cycle; req_ready returns to 1 at T+3.
2. Request 0x00 with resp_ready=0 for 4 cycles after resp_valid, then 1 -> resp_data stays 0x11111111 and resp_valid stays high for all 4 stalled cycles, then clears next cycle; req_valid driven during the stall is not accepted.
3. DEPTH=200, request 0xC8 -> resp_err=1, resp_data=0x00000000; a load to 0xC8 leaves the next fetch of 0xC8 still erroring.
4. Request 0x05 while load_en writes 0xCAFEF00D to 0x05 in the same cycle -> response is 0xDEADBEEF. A following request to 0x05 -> 0xCAFEF00D.
5. Assert reset during BUSY, then during RESP -> resp_valid drops with no clock edge and state returns to IDLE. After release, a fetch of 0x05 returns the pre-reset memory value.
6. Back-to-back requests 0x00,0x05,0x00 with req_valid held and resp_ready=1, LATENCY=1 -> exactly three responses in order, spaced 3 cycles apart, with matching data.
